// File: rtl/csr_spmv_engine.sv
// rtl/csr_spmv_engine.sv - CSR sparse-matrix x dense-vector engine (y = A*x)
// One load port fills row_ptr/val/col/x RAMs; a start pulse streams y row by row over valid/ready.
module csr_spmv_engine #(
  parameter int DW       = 32,
  parameter int ACCW     = 64,
  parameter int MAX_ROWS = 1024,
  parameter int MAX_NNZ  = 16384,
  parameter int MAX_COLS = 1024,
  parameter int CW       = $clog2(MAX_COLS),
  parameter int AW       = $clog2(MAX_NNZ + 1),
  parameter int RW       = $clog2(MAX_ROWS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [1:0]      wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [CW-1:0]   wr_col,
  output logic            wr_ready,
  input  logic            start,
  input  logic [RW-1:0]   nrows,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RW-1:0]   out_row,
  output logic [ACCW-1:0] out_data,
  output logic            out_zero,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int VW = $clog2(MAX_NNZ);
  localparam logic [AW-1:0] NNZ_LIM    = AW'(MAX_NNZ);
  localparam logic [AW-1:0] RP_TOP     = AW'(MAX_ROWS);
  localparam logic [AW-1:0] X_LIM      = AW'(MAX_COLS);
  localparam logic [RW-1:0] ROWS_LIM   = RW'(MAX_ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_PTR0, S_PTR1, S_MAC, S_DRAIN, S_EMIT, S_FIN
  } state_t;

  state_t state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [RW-1:0]   nrows_q, nrows_d;
  logic [AW-1:0]   k_q, k_d;
  logic [AW-1:0]   p1_q, p1_d;
  logic [1:0]      dcnt_q, dcnt_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
  logic            s1_v_q, s1_v_d;
  logic            s2_v_q, s2_v_d;

  logic [AW-1:0] rp_mem  [0:MAX_ROWS];
  logic [DW-1:0] val_mem [0:MAX_NNZ-1];
  logic [CW-1:0] col_mem [0:MAX_NNZ-1];
  logic [DW-1:0] x_mem   [0:MAX_COLS-1];

  logic [AW-1:0] rp0_rd_q, rp1_rd_q;
  logic [DW-1:0] val_rd_q, val2_q, x_rd_q;
  logic [CW-1:0] col_rd_q;

  logic                   wr_fire;
  logic [RW-1:0]          r_nxt;
  logic                   ptr_bad;
  logic signed [2*DW-1:0] prod;
  logic [ACCW-1:0]        prod_ext;

  assign wr_fire  = wr_en && (state_q == S_IDLE);
  assign r_nxt    = r_q + RW'(1);
  assign ptr_bad  = (rp1_rd_q < rp0_rd_q) || (rp1_rd_q > NNZ_LIM);
  assign prod     = $signed(val2_q) * $signed(x_rd_q);
  assign prod_ext = ACCW'(prod);

  // RAMs: out-of-range load addresses are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (wr_fire && wr_sel == 2'd0 && wr_addr <= RP_TOP)
      rp_mem[wr_addr[RW-1:0]] <= wr_data[AW-1:0];
    if (wr_fire && wr_sel == 2'd1 && wr_addr < NNZ_LIM) begin
      val_mem[wr_addr[VW-1:0]] <= wr_data;
      col_mem[wr_addr[VW-1:0]] <= wr_col;
    end
    if (wr_fire && wr_sel == 2'd2 && wr_addr < X_LIM)
      x_mem[wr_addr[CW-1:0]] <= wr_data;
    if (state_q == S_PTR0) begin
      rp0_rd_q <= rp_mem[r_q];
      rp1_rd_q <= rp_mem[r_nxt];
    end
    val_rd_q <= val_mem[k_q[VW-1:0]];
    col_rd_q <= col_mem[k_q[VW-1:0]];
    x_rd_q   <= x_mem[col_rd_q];
    val2_q   <= val_rd_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      nrows_q <= '0;
      k_q     <= '0;
      p1_q    <= '0;
      dcnt_q  <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      nrows_q <= nrows_d;
      k_q     <= k_d;
      p1_q    <= p1_d;
      dcnt_q  <= dcnt_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    nrows_d = nrows_q;
    k_d     = k_q;
    p1_d    = p1_q;
    dcnt_d  = dcnt_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    err_d   = err_q;
    s1_v_d  = (state_q == S_MAC);
    s2_v_d  = s1_v_q;
    if (s2_v_q)
      acc_d = acc_q + prod_ext;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d     = '0;
          err_d   = 1'b0;
          nrows_d = (nrows > ROWS_LIM) ? ROWS_LIM : nrows;
          state_d = (nrows == '0) ? S_FIN : S_PTR0;
        end
      end
      S_PTR0: state_d = S_PTR1;
      S_PTR1: begin
        acc_d  = '0;
        zero_d = 1'b0;
        if (ptr_bad) begin
          err_d   = 1'b1;
          state_d = S_EMIT;
        end else if (rp1_rd_q == rp0_rd_q) begin
          zero_d  = 1'b1;
          state_d = S_EMIT;
        end else begin
          k_d     = rp0_rd_q;
          p1_d    = rp1_rd_q;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        k_d = k_q + AW'(1);
        if (k_q + AW'(1) == p1_q) begin
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end
      end
      // Three cycles cover the val/col read, x read and accumulate stages.
      S_DRAIN: begin
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == 2'd2)
          state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          r_d     = r_nxt;
          state_d = (r_nxt < nrows_q) ? S_PTR0 : S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_EMIT);
    done      = (state_q == S_FIN);
  end

  assign out_row  = r_q;
  assign out_data = acc_q;
  assign out_zero = zero_q;
  assign err      = err_q;

endmodule
